// File: rtl/clk_rec.sv
// clk_rec: clock/data recovery core.
// Measures edge-to-edge run lengths on an asynchronous serial input, trains a
// bit-period estimate from the minimum qualifying run, then runs a
// phase-realigned bit clock, a mid-bit sample strobe and recovered data with
// lock/loss detection.
// Optional feature: define CLK_REC_TRACK_EN to let the locked period follow
// slow drift by +/-1 per edge; otherwise the period is frozen while locked.
module clk_rec #(
    parameter int W      = 32,
    parameter int R      = 8,
    parameter int T      = 2,
    parameter int L      = 16,
    parameter int SYNC_N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         data_i,
    output logic         clk_gen_o,
    output logic         sample_o,
    output logic         data_o,
    output logic         lock_o,
    output logic [W-1:0] period_o
);

    localparam int TCW = (R > 1) ? $clog2(R) : 1;
    localparam int MW  = $clog2(L + 1);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_TRAIN = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [SYNC_N-1:0] r_sync;
    logic              r_prev;
    logic [W-1:0]      r_cnt;
    logic [W-1:0]      r_min;
    logic [TCW-1:0]    r_tc;
    logic [W-1:0]      r_period;
    logic [W-1:0]      r_ph;
    logic [MW-1:0]     r_miss;

    logic              w_sdat;
    logic              w_edge;
    logic [W-1:0]      w_run;
    logic              w_noise;
    logic              w_qual;
    logic              w_min_upd;
    logic              w_tc_full;
    logic [W-1:0]      w_half;
    logic              w_wrap;
    logic [W-1:0]      w_thr;
    logic              w_fast;
    logic [MW-1:0]     w_miss_inc;
    logic              w_lost;

    logic              w_lock_nxt;
    logic              w_cg_nxt;
    logic              w_smp_nxt;

    // Edge detection and run classification
    assign w_sdat     = r_sync[SYNC_N-1];
    assign w_edge     = w_sdat ^ r_prev;
    assign w_run      = r_cnt;
    assign w_noise    = (w_run < W'(4));
    assign w_qual     = w_edge && !w_noise;
    assign w_min_upd  = w_qual && (w_run < r_min);
    assign w_tc_full  = (r_tc == TCW'(R - 1));

    // Phase bookkeeping; a run below period-T means the line got faster
    assign w_half     = r_period >> 1;
    assign w_wrap     = (r_ph >= r_period - W'(1));
    assign w_thr      = (r_period > W'(T)) ? (r_period - W'(T)) : '0;
    assign w_fast     = w_qual && (w_run < w_thr);
    assign w_miss_inc = r_miss + MW'(1);
    assign w_lost     = w_wrap && (w_miss_inc == MW'(L));

    // Input synchronizer plus one delayed copy for the edge detector
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], data_i};
            r_prev <= w_sdat;
        end
    end

    // Run counter: cycles since the last edge, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: edge has priority over wrap-driven loss of lock
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT: begin
                if (w_edge) w_state_nxt = S_TRAIN;
            end
            S_TRAIN: begin
                if (w_qual && !w_min_upd && w_tc_full) w_state_nxt = S_LOCK;
            end
            S_LOCK: begin
                if (w_edge) begin
                    if (w_fast) w_state_nxt = S_TRAIN;
                end else if (w_lost) begin
                    w_state_nxt = S_HUNT;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // FSM outputs (registered below); an edge suppresses the mid-bit sample
    always_comb begin
        w_lock_nxt = (r_state == S_LOCK);
        w_cg_nxt   = (r_state == S_LOCK) && (r_ph < w_half);
        w_smp_nxt  = (r_state == S_LOCK) && !w_edge && (r_ph == w_half);
    end

    // Training datapath: minimum run, qualifying-edge count, period estimate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_min    <= '1;
            r_tc     <= '0;
            r_period <= '0;
        end else begin
            case (r_state)
                S_TRAIN: begin
                    if (w_edge) begin
                        if (w_noise) begin
                            r_tc <= '0;
                        end else if (w_min_upd) begin
                            r_min <= w_run;
                            r_tc  <= '0;
                        end else if (w_tc_full) begin
                            r_period <= r_min;
                        end else begin
                            r_tc <= r_tc + TCW'(1);
                        end
                    end
                end
                S_LOCK: begin
                    if (w_edge) begin
                        if (w_fast) begin
                            r_min <= w_run;
                            r_tc  <= '0;
                        end
`ifdef CLK_REC_TRACK_EN
                        // Nudge the period one count toward a near-miss run
                        else if (w_qual && (w_run > r_period) &&
                                 (w_run - r_period <= W'(T))) begin
                            r_period <= r_period + W'(1);
                        end else if (w_qual && (w_run < r_period) &&
                                     (r_period - w_run <= W'(T))) begin
                            r_period <= r_period - W'(1);
                        end
`endif
                    end else if (w_lost) begin
                        // Back to HUNT: next training starts from scratch
                        r_min <= '1;
                        r_tc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase counter and miss counter; any edge (noise included) realigns phase
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ph   <= '0;
            r_miss <= '0;
        end else if (r_state != S_LOCK) begin
            r_ph   <= '0;
            r_miss <= '0;
        end else if (w_edge) begin
            r_ph   <= '0;
            r_miss <= '0;
        end else if (w_wrap) begin
            r_ph   <= '0;
            r_miss <= w_miss_inc;
        end else begin
            r_ph   <= r_ph + W'(1);
        end
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_gen_o <= 1'b0;
            sample_o  <= 1'b0;
            data_o    <= 1'b0;
            lock_o    <= 1'b0;
            period_o  <= '0;
        end else begin
            clk_gen_o <= w_cg_nxt;
            sample_o  <= w_smp_nxt;
            lock_o    <= w_lock_nxt;
            period_o  <= r_period;
            if (w_smp_nxt) data_o <= w_sdat;
        end
    end

endmodule
